alu_unit: RTL and testbench



---
 rtl/alu_unit.sv | 65 ++++++
 tb/tb_alu_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// 8-bit, 16-operation ALU with a registered 16-bit result and a tri-stateable
// output, so several units can share one result bus.
module alu_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [3:0]  command,
   input  logic        oe,
   output logic [15:0] y
);

   logic [15:0] res;
   logic [15:0] res_next;

   // Operands are zero-extended first so arithmetic wraps modulo 2^16.
   // An X/Z command matches no item and falls through to the zero default.
   function automatic logic [15:0] alu_op(input logic [7:0]  op_a,
                                          input logic [7:0]  op_b,
                                          input logic [3:0]  cmd);
      logic [15:0] ax;
      logic [15:0] bx;
      logic [15:0] r;
      ax = {8'h00, op_a};
      bx = {8'h00, op_b};
      r  = 16'h0000;
      case (cmd)
         4'b0000: r = ax + bx;
         4'b0001: r = ax + 16'd1;
         4'b0010: r = ax - bx;
         4'b0011: r = ax - 16'd1;
         4'b0100: r = ax * bx;
         4'b0101: r = (op_b == 8'h00) ? 16'hFFFF : ax / bx;
         4'b0110: r = ax << 1;
         4'b0111: r = ax >> 1;
         4'b1000: r = ax & bx;
         4'b1001: r = ax | bx;
         4'b1010: r = {8'h00, ~op_a};
         4'b1011: r = {8'h00, ~(op_a & op_b)};
         4'b1100: r = {8'h00, ~(op_a | op_b)};
         4'b1101: r = ax ^ bx;
         4'b1110: r = {8'h00, ~(op_a ^ op_b)};
         4'b1111: r = ax;
         default: r = 16'h0000;
      endcase
      return r;
   endfunction

   always_comb begin
      res_next = alu_op(a, b, command);
   end

   // Result register: one cycle of latency, a new operation every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res <= 16'h0000;
      end else begin
         res <= res_next;
      end
   end

   // Output enable is purely combinational.
   assign y = oe ? res : 16'bz;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit; y sits on a pulled-up net, so a floating
// (high-Z) output reads back as 16'hFFFF.
module tb_alu_unit;

   logic        clk;
   logic        rst;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [3:0]  command;
   logic        oe;
   tri1  [15:0] y;

   int n_checks;
   int n_fails;

   localparam logic [15:0] FLOAT = 16'hFFFF;

   alu_unit dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .command (command),
      .oe      (oe),
      .y       (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] exp);
      n_checks++;
      assert (y === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, y, exp);
      end
   endtask

   // Drive one operation away from the edge, clock it in, sample 1 ns later.
   task automatic op(input logic [7:0] va, input logic [7:0] vb,
                     input logic [3:0] vc, input logic [15:0] exp,
                     input string tag);
      @(negedge clk);
      a = va;
      b = vb;
      command = vc;
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst = 1'b1;
      oe  = 1'b1;
      a = 8'h33;
      b = 8'h44;
      command = 4'b0000;
      #2;
      check("reset_y", 16'h0000);
      @(posedge clk);
      #1;
      check("reset_hold", 16'h0000);

      @(negedge clk);
      rst = 1'b0;
      op(8'h0A, 8'h05, 4'b0000, 16'h000F, "add_0a_05");

      // Output enable toggles without a clock.
      @(negedge clk);
      oe = 1'b0;
      #1;
      check("oe_low_float", FLOAT);
      oe = 1'b1;
      #1;
      check("oe_high_restore", 16'h000F);

      // Inputs only take effect at an edge.
      a = 8'h01;
      b = 8'h01;
      command = 4'b0100;
      #2;
      check("between_edges_hold", 16'h000F);

      op(8'h0A, 8'h05, 4'b0010, 16'h0005, "sub_10_5");
      op(8'h0A, 8'h05, 4'b0111, 16'h0005, "shr_10");
      op(8'h0A, 8'h05, 4'b1111, 16'h000A, "buf_10");
      op(8'h0A, 8'h05, 4'b1000, 16'h0000, "and_10_5");
      op(8'h0A, 8'h05, 4'b1001, 16'h000F, "or_10_5");
      op(8'h0A, 8'h05, 4'b1101, 16'h000F, "xor_10_5");
      op(8'hFF, 8'h01, 4'b0000, 16'h0100, "add_carry");
      op(8'hFF, 8'hFF, 4'b0100, 16'hFE01, "mul_ff_ff");
      op(8'h03, 8'h05, 4'b0010, 16'hFFFE, "sub_neg");
      op(8'h00, 8'h00, 4'b0011, 16'hFFFF, "dec_zero");
      op(8'hFF, 8'h00, 4'b0001, 16'h0100, "inc_ff");
      op(8'h0A, 8'h00, 4'b0101, 16'hFFFF, "div_by_zero");
      op(8'h0A, 8'h03, 4'b0101, 16'h0003, "div_0a_03");
      op(8'h81, 8'h00, 4'b0110, 16'h0102, "shl_81");
      op(8'h0F, 8'h00, 4'b1010, 16'h00F0, "inv_0f");
      op(8'hFF, 8'hFF, 4'b1011, 16'h0000, "nand_ff_ff");
      op(8'hF0, 8'h0C, 4'b1100, 16'h0003, "nor_f0_0c");
      op(8'hF0, 8'h3C, 4'b1110, 16'h0033, "xnor_f0_3c");

      // New result loaded while floating becomes visible on enable.
      op(8'h0A, 8'h05, 4'b0000, 16'h000F, "add_before_oe");
      @(negedge clk);
      oe = 1'b0;
      a = 8'h0A;
      command = 4'b1111;
      @(posedge clk);
      #1;
      check("oe_low_after_edge", FLOAT);
      oe = 1'b1;
      #1;
      check("oe_high_new_result", 16'h000A);

      // Asynchronous reset between edges clears y at once.
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("async_reset_now", 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      a = 8'hFF;
      b = 8'h01;
      command = 4'b0000;
      #1;
      check("after_release_pre_edge", 16'h0000);
      @(posedge clk);
      #1;
      check("first_edge_after_reset", 16'h0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish, expected finish within 20000 ns");
      $fatal(1, "timeout");
   end

endmodule
